// File: rtl/tr_bus_scheduler.sv
// tr_bus_scheduler
//   Arbitrates the single downstream register-write bus between two requesters:
//   - a receiver write path that is buffered in a one-entry holding register
//   - a GPS/status snapshot sequencer that runs on every 1PPS rising edge. It walks
//     a snapshot register file and writes each enabled word to BASE_ADDR+index.
//   Each issue raises TR_IN for one cycle and spends one GAP cycle. The FSM then
//   waits in WAIT until the sink drops TR_IN_BUSY.
//
// Ports
//   CLK, RESET           clock, synchronous active-high reset
//   Reveiver_priority    priority flag captured with the receiver strobe
//   Reveiver_ADDR/DATA   receiver write address / data
//   Reveiver_TR          receiver 1-cycle write strobe
//   Reveiver_TR_IN_BUSY  holding register occupied
//   GPS_1PPS             asynchronous 1PPS input
//   SNAP_IDX             snapshot register file read index
//   SNAP_DATA            snapshot register file read data (combinational on SNAP_IDX)
//   SNAP_BUSY            snapshot burst in progress
//   SNAP_OVERRUN         sticky: 1PPS edge seen during a burst
//   RX_OVERRUN           sticky: receiver strobe dropped because the holding register was full
//   TR_IN/ADDR_IN/DATA_IN  write strobe, address and data to the sink
//   TR_IN_BUSY           sink busy

`timescale 1ns/1ps

module tr_bus_scheduler #(
    parameter logic [15:0] BASE_ADDR = 16'd300,
    parameter int unsigned NUM_WORDS = 21,
    parameter logic [31:0] SNAP_MASK = 32'h0010_3F7F
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Reveiver_priority,
    input  logic [15:0] Reveiver_ADDR,
    input  logic [31:0] Reveiver_DATA,
    input  logic        Reveiver_TR,
    output logic        Reveiver_TR_IN_BUSY,
    input  logic        GPS_1PPS,
    output logic [4:0]  SNAP_IDX,
    input  logic [31:0] SNAP_DATA,
    output logic        SNAP_BUSY,
    output logic        SNAP_OVERRUN,
    output logic        RX_OVERRUN,
    output logic        TR_IN,
    output logic [15:0] ADDR_IN,
    output logic [31:0] DATA_IN,
    input  logic        TR_IN_BUSY
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 5;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t         state_q;

    // 1PPS synchroniser plus one delayed copy for edge detection
    logic           pps_meta_q;
    logic           pps_sync_q;
    logic           pps_prev_q;

    // receiver holding register
    logic           rx_valid_q;
    logic           rx_prio_q;
    logic [AW-1:0]  rx_addr_q;
    logic [DW-1:0]  rx_data_q;
    logic           rx_ovr_q;

    // snapshot sequencer
    logic           snap_busy_q;
    logic [IW-1:0]  snap_idx_q;
    logic           snap_ovr_q;

    // bus outputs
    logic           tr_q;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  data_q;

    logic           pps_rise;
    logic           rx_sel;
    logic           snap_sel;
    logic           skip_sel;
    logic           snap_last;

    assign pps_rise  = pps_sync_q & ~pps_prev_q;
    assign snap_last = (snap_idx_q == LAST_IDX);

    // IDLE arbitration. A priority receiver word wins between snapshot words.
    // A normal receiver word waits until the burst is over.
    always_comb begin
        rx_sel   = 1'b0;
        snap_sel = 1'b0;
        skip_sel = 1'b0;
        if (state_q == ST_IDLE && !TR_IN_BUSY) begin
            if (rx_valid_q && (rx_prio_q || !snap_busy_q)) begin
                rx_sel = 1'b1;
            end else if (snap_busy_q && SNAP_MASK[snap_idx_q]) begin
                snap_sel = 1'b1;
            end else if (snap_busy_q) begin
                skip_sel = 1'b1;
            end
        end
    end

    // All state, the sequencer and the bus FSM
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            pps_meta_q  <= 1'b0;
            pps_sync_q  <= 1'b0;
            pps_prev_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_prio_q   <= 1'b0;
            rx_addr_q   <= '0;
            rx_data_q   <= '0;
            rx_ovr_q    <= 1'b0;
            snap_busy_q <= 1'b0;
            snap_idx_q  <= '0;
            snap_ovr_q  <= 1'b0;
            tr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            pps_meta_q <= GPS_1PPS;
            pps_sync_q <= pps_meta_q;
            pps_prev_q <= pps_sync_q;

            tr_q <= 1'b0;

            // Receiver capture. A strobe while the register is full is lost.
            if (Reveiver_TR) begin
                if (!rx_valid_q) begin
                    rx_valid_q <= 1'b1;
                    rx_prio_q  <= Reveiver_priority;
                    rx_addr_q  <= Reveiver_ADDR;
                    rx_data_q  <= Reveiver_DATA;
                end else begin
                    rx_ovr_q <= 1'b1;
                end
            end
            if (rx_sel) begin
                rx_valid_q <= 1'b0;
            end

            // Burst start. An edge during a running burst only flags an overrun.
            if (pps_rise) begin
                if (!snap_busy_q) begin
                    snap_busy_q <= 1'b1;
                    snap_idx_q  <= '0;
                end else begin
                    snap_ovr_q <= 1'b1;
                end
            end
            if (snap_sel || skip_sel) begin
                snap_idx_q <= snap_idx_q + IW'(1);
                if (snap_last) begin
                    snap_busy_q <= 1'b0;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (rx_sel) begin
                        tr_q    <= 1'b1;
                        addr_q  <= rx_addr_q;
                        data_q  <= rx_data_q;
                        state_q <= ST_GAP;
                    end else if (snap_sel) begin
                        tr_q    <= 1'b1;
                        addr_q  <= BASE_ADDR + AW'(snap_idx_q);
                        data_q  <= SNAP_DATA;
                        state_q <= ST_GAP;
                    end
                end
                // The sink gets one cycle to raise TR_IN_BUSY before it is sampled
                ST_GAP: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!TR_IN_BUSY) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Reveiver_TR_IN_BUSY = rx_valid_q;
    assign RX_OVERRUN          = rx_ovr_q;
    assign SNAP_IDX            = snap_idx_q;
    assign SNAP_BUSY           = snap_busy_q;
    assign SNAP_OVERRUN        = snap_ovr_q;
    assign TR_IN               = tr_q;
    assign ADDR_IN             = addr_q;
    assign DATA_IN             = data_q;

endmodule

// File: tb/tb_tr_bus_scheduler.sv
// Testbench for tr_bus_scheduler.
// The scoreboard holds the expected sink writes in order.
// A negedge monitor pops one entry per strobe and compares it with the DUT output.

`timescale 1ns/1ps

module tb_tr_bus_scheduler;

    localparam logic [31:0] MASK = 32'h0010_3F7F;
    localparam int          NW   = 21;
    localparam int          BASE = 300;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        Reveiver_priority = 1'b0;
    logic [15:0] Reveiver_ADDR = '0;
    logic [31:0] Reveiver_DATA = '0;
    logic        Reveiver_TR = 1'b0;
    logic        Reveiver_TR_IN_BUSY;
    logic        GPS_1PPS = 1'b0;
    logic [4:0]  SNAP_IDX;
    logic [31:0] SNAP_DATA;
    logic        SNAP_BUSY;
    logic        SNAP_OVERRUN;
    logic        RX_OVERRUN;
    logic        TR_IN;
    logic [15:0] ADDR_IN;
    logic [31:0] DATA_IN;
    logic        TR_IN_BUSY = 1'b0;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [31:0] snap_seed = 32'hA5A5_0000;
    bit   slow_sink = 1'b0;

    tr_bus_scheduler dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .Reveiver_priority   (Reveiver_priority),
        .Reveiver_ADDR       (Reveiver_ADDR),
        .Reveiver_DATA       (Reveiver_DATA),
        .Reveiver_TR         (Reveiver_TR),
        .Reveiver_TR_IN_BUSY (Reveiver_TR_IN_BUSY),
        .GPS_1PPS            (GPS_1PPS),
        .SNAP_IDX            (SNAP_IDX),
        .SNAP_DATA           (SNAP_DATA),
        .SNAP_BUSY           (SNAP_BUSY),
        .SNAP_OVERRUN        (SNAP_OVERRUN),
        .RX_OVERRUN          (RX_OVERRUN),
        .TR_IN               (TR_IN),
        .ADDR_IN             (ADDR_IN),
        .DATA_IN             (DATA_IN),
        .TR_IN_BUSY          (TR_IN_BUSY)
    );

    always #5 CLK = ~CLK;

    // snapshot register file model: each word is a function of its index
    assign SNAP_DATA = snap_seed ^ (32'(SNAP_IDX) * 32'h0101_0101);

    function automatic logic [31:0] snap_word(input logic [31:0] seed, input int i);
        return seed ^ (32'(i) * 32'h0101_0101);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_range(input int lo, input int hi);
        exp_t e;
        for (int i = lo; i <= hi; i++) begin
            if (MASK[i]) begin
                e.a = 16'(BASE + i);
                e.d = snap_word(snap_seed, i);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_rx(input logic [15:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic pulse_pps();
        @(negedge CLK);
        GPS_1PPS = 1'b1;
        repeat (4) @(negedge CLK);
        GPS_1PPS = 1'b0;
    endtask

    task automatic wait_strobe(input logic [15:0] a, input int maxc);
        bit found = 1'b0;
        for (int i = 0; i < maxc && !found; i++) begin
            @(negedge CLK);
            if (TR_IN && ADDR_IN == a) found = 1'b1;
        end
        chk($sformatf("strobe_%0d_seen", a), 64'(found), 64'd1);
    endtask

    task automatic drain(input string tag, input int maxc);
        bit done = 1'b0;
        for (int i = 0; i < maxc && !done; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !SNAP_BUSY && !Reveiver_TR_IN_BUSY) done = 1'b1;
        end
        repeat (8) @(negedge CLK);
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Sink model: with slow_sink set, it holds TR_IN_BUSY for 10 cycles after each strobe
    int hold = 0;
    always @(negedge CLK) begin
        if (RESET) begin
            hold = 0;
            TR_IN_BUSY = 1'b0;
        end else if (TR_IN && slow_sink) begin
            hold = 10;
            TR_IN_BUSY = 1'b1;
        end else if (hold > 0) begin
            hold--;
            TR_IN_BUSY = (hold != 0);
        end
    end

    // Monitor: compare each strobe with the scoreboard, and check that ADDR_IN/DATA_IN hold between strobes
    int          cyc = 0;
    int          last_cyc = 0;
    bit          have_last = 1'b0;
    bit          prev_tr = 1'b0;
    logic [15:0] last_a = '0;
    logic [31:0] last_d = '0;
    always @(negedge CLK) begin
        exp_t e;
        cyc++;
        if (RESET) begin
            exp_q.delete();
            have_last = 1'b0;
            prev_tr   = 1'b0;
        end else begin
            if (TR_IN) begin
                chk("no_back_to_back_strobe", 64'(prev_tr), 64'd0);
                chk("strobe_expected", 64'(exp_q.size() != 0), 64'd1);
                if (slow_sink && have_last) chk("slow_sink_gap_ge_12", 64'((cyc - last_cyc) >= 12), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("ADDR_IN", 64'(ADDR_IN), 64'(e.a));
                    chk("DATA_IN", 64'(DATA_IN), 64'(e.d));
                    last_a    = e.a;
                    last_d    = e.d;
                    have_last = 1'b1;
                end else begin
                    have_last = 1'b0;
                end
                last_cyc = cyc;
            end else if (have_last) begin
                chk("ADDR_IN_hold", 64'(ADDR_IN), 64'(last_a));
                chk("DATA_IN_hold", 64'(DATA_IN), 64'(last_d));
            end
            prev_tr = TR_IN;
        end
    end

    initial begin
        // reset values
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        chk("rst_TR_IN", 64'(TR_IN), 64'd0);
        chk("rst_SNAP_BUSY", 64'(SNAP_BUSY), 64'd0);
        chk("rst_SNAP_IDX", 64'(SNAP_IDX), 64'd0);
        chk("rst_ADDR_IN", 64'(ADDR_IN), 64'd0);
        chk("rst_DATA_IN", 64'(DATA_IN), 64'd0);
        chk("rst_rx_busy", 64'(Reveiver_TR_IN_BUSY), 64'd0);
        chk("rst_SNAP_OVERRUN", 64'(SNAP_OVERRUN), 64'd0);
        chk("rst_RX_OVERRUN", 64'(RX_OVERRUN), 64'd0);
        repeat (3) @(negedge CLK);

        // full burst with the default mask
        push_range(0, NW - 1);
        pulse_pps();
        wait_strobe(16'd313, 200);
        chk("burst_busy_at_313", 64'(SNAP_BUSY), 64'd1);
        wait_strobe(16'd320, 200);
        chk("burst_busy_clear_at_320", 64'(SNAP_BUSY), 64'd0);
        drain("burst", 200);

        // non-priority receiver word waits for the whole burst
        snap_seed = 32'h1357_9BDF;
        push_range(0, NW - 1);
        push_rx(16'h0010, 32'hDEAD_BEEF);
        pulse_pps();
        wait_strobe(16'd302, 200);
        Reveiver_TR = 1'b1; Reveiver_priority = 1'b0;
        Reveiver_ADDR = 16'h0010; Reveiver_DATA = 32'hDEAD_BEEF;
        @(negedge CLK);
        Reveiver_TR = 1'b0;
        chk("np_rx_busy_after_capture", 64'(Reveiver_TR_IN_BUSY), 64'd1);
        wait_strobe(16'd320, 200);
        chk("np_rx_busy_at_320", 64'(Reveiver_TR_IN_BUSY), 64'd1);
        wait_strobe(16'h0010, 50);
        @(negedge CLK);
        chk("np_rx_busy_cleared", 64'(Reveiver_TR_IN_BUSY), 64'd0);
        drain("nonprio", 200);

        // priority receiver word slots in right after the in-flight word
        snap_seed = 32'h0F0F_C3C3;
        push_range(0, 2);
        push_rx(16'h0020, 32'h1234_5678);
        push_range(3, NW - 1);
        pulse_pps();
        wait_strobe(16'd302, 200);
        Reveiver_TR = 1'b1; Reveiver_priority = 1'b1;
        Reveiver_ADDR = 16'h0020; Reveiver_DATA = 32'h1234_5678;
        @(negedge CLK);
        Reveiver_TR = 1'b0; Reveiver_priority = 1'b0;
        drain("prio", 200);

        // slow sink: busy held 10 cycles after each strobe
        snap_seed = 32'h7777_1111;
        slow_sink = 1'b1;
        push_range(0, NW - 1);
        pulse_pps();
        drain("slow_sink", 500);
        slow_sink = 1'b0;

        // second 1PPS mid-burst: overrun flagged, burst unchanged
        snap_seed = 32'h2468_ACE0;
        push_range(0, NW - 1);
        pulse_pps();
        wait_strobe(16'd302, 200);
        chk("snap_ovr_before", 64'(SNAP_OVERRUN), 64'd0);
        pulse_pps();
        repeat (3) @(negedge CLK);
        chk("snap_ovr_after", 64'(SNAP_OVERRUN), 64'd1);
        drain("pps_overrun", 200);

        // two receiver strobes on consecutive cycles: the second one is dropped
        push_rx(16'h0040, 32'hCAFE_0001);
        Reveiver_TR = 1'b1; Reveiver_ADDR = 16'h0040; Reveiver_DATA = 32'hCAFE_0001;
        @(negedge CLK);
        Reveiver_ADDR = 16'h0041; Reveiver_DATA = 32'hCAFE_0002;
        @(negedge CLK);
        Reveiver_TR = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rx_ovr_set", 64'(RX_OVERRUN), 64'd1);
        drain("rx_overrun", 50);

        // reset mid-burst after three words
        snap_seed = 32'h5555_AAAA;
        push_range(0, NW - 1);
        pulse_pps();
        wait_strobe(16'd302, 200);
        RESET = 1'b1;
        @(negedge CLK);
        chk("midrst_TR_IN", 64'(TR_IN), 64'd0);
        chk("midrst_SNAP_BUSY", 64'(SNAP_BUSY), 64'd0);
        chk("midrst_SNAP_IDX", 64'(SNAP_IDX), 64'd0);
        chk("midrst_SNAP_OVERRUN", 64'(SNAP_OVERRUN), 64'd0);
        chk("midrst_RX_OVERRUN", 64'(RX_OVERRUN), 64'd0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (80) @(negedge CLK);
        chk("midrst_no_busy", 64'(SNAP_BUSY), 64'd0);
        chk("midrst_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
